// File: rtl/axi4_lite_pkg.sv
// Shared channel payload layouts, width helpers and the depth legality check for the AXI4-Lite slice.
package axi4_lite_pkg;

  localparam int A_DEF        = 32;
  localparam int N_DEF        = 4;
  localparam int USE_STRB_DEF = 1;

  typedef struct packed { logic [A_DEF-1:0] addr; } ar_t;
  typedef struct packed { logic [A_DEF-1:0] addr; } aw_t;
  typedef struct packed { logic [8*N_DEF-1:0] data; logic [N_DEF-1:0] strb; } w_strb_t;
  typedef struct packed { logic [8*N_DEF-1:0] data; } w_nostrb_t;
  typedef struct packed { logic [1:0] resp; } b_t;
  typedef struct packed { logic [8*N_DEF-1:0] data; logic [1:0] resp; } r_t;

  function automatic int ar_w(input int a);
    return a;
  endfunction

  function automatic int aw_w(input int a);
    return a;
  endfunction

  function automatic int w_w(input int n, input int use_strb);
    return (use_strb != 0) ? 9 * n : 8 * n;
  endfunction

  function automatic int b_w();
    return 2;
  endfunction

  function automatic int r_w(input int n);
    return 8 * n + 2;
  endfunction

  // Occupancy port width; a pass-through channel still gets a 1-bit port.
  function automatic int cnt_w(input int depth);
    return (depth == 0) ? 1 : $clog2(depth + 1);
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth == 0) || (depth == 2) ||
           ((depth >= 4) && (depth <= 64) && ((depth & (depth - 1)) == 0));
  endfunction

  localparam int AR_W = ar_w(A_DEF);
  localparam int AW_W = aw_w(A_DEF);
  localparam int W_W  = w_w(N_DEF, USE_STRB_DEF);
  localparam int B_W  = b_w();
  localparam int R_W  = r_w(N_DEF);

endpackage

// File: rtl/axi4_lite_chan_buf.sv
// One channel buffer: pass-through (DEPTH 0), skid buffer (DEPTH 2) or circular FIFO (DEPTH 4..64).
// Skid states:  EMPTY | nothing held   ONE | output register valid   FULL | output and skid registers valid
module axi4_lite_chan_buf
  import axi4_lite_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  localparam int CW   = cnt_w(DEPTH)
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic [W-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] count
);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("axi4_lite_chan_buf: illegal DEPTH %0d", DEPTH);
  end

  if (DEPTH == 0) begin : g_pass
    logic unused_clk;
    assign unused_clk = aclk ^ areset;
    assign out_data   = in_data;
    assign out_valid  = in_valid;
    assign in_ready   = out_ready;
    assign count      = '0;
  end else if (DEPTH == 2) begin : g_skid
    typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_state_t;
    skid_state_t   state;
    logic [W-1:0]  out_q, skid_q;
    logic          valid_q, ready_q;
    logic [CW-1:0] cnt_q;
    logic          in_beat, out_beat;

    assign in_beat  = in_valid & ready_q;
    assign out_beat = valid_q & out_ready;

    always_ff @(posedge aclk) begin
      if (areset) begin
        state   <= EMPTY;
        out_q   <= '0;
        skid_q  <= '0;
        valid_q <= 1'b0;
        ready_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        case (state)
          EMPTY: begin
            ready_q <= 1'b1;
            if (in_beat) begin
              out_q   <= in_data;
              valid_q <= 1'b1;
              cnt_q   <= CW'(1);
              state   <= ONE;
            end
          end
          ONE: begin
            if (in_beat && !out_beat) begin
              skid_q  <= in_data;
              ready_q <= 1'b0;
              cnt_q   <= CW'(2);
              state   <= FULL;
            end else if (in_beat) begin
              out_q <= in_data;
            end else if (out_beat) begin
              valid_q <= 1'b0;
              cnt_q   <= '0;
              state   <= EMPTY;
            end
          end
          FULL: begin
            if (out_beat) begin
              out_q   <= skid_q;
              ready_q <= 1'b1;
              cnt_q   <= CW'(1);
              state   <= ONE;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end

    assign out_data  = out_q;
    assign out_valid = valid_q;
    assign in_ready  = ready_q;
    assign count     = cnt_q;
  end else begin : g_fifo
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] cnt_q;
    logic          live_q;
    logic          push, pop;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // live_q holds ready low through reset and the first cycle after it.
    always_ff @(posedge aclk) begin
      if (areset) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt_q  <= '0;
        live_q <= 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
        live_q <= 1'b1;
        if (push) begin
          mem[wr_ptr] <= in_data;
          wr_ptr      <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   cnt_q <= cnt_q + CW'(1);
          2'b01:   cnt_q <= cnt_q - CW'(1);
          default: cnt_q <= cnt_q;
        endcase
      end
    end

    assign in_ready  = live_q & (cnt_q != CW'(DEPTH));
    assign out_valid = (cnt_q != '0);
    assign out_data  = mem[rd_ptr];
    assign count     = cnt_q;
  end

endmodule

// File: rtl/axi4_lite_reg_slice.sv
// AXI4-Lite register slice: each of the five channels is flattened and passed through its own buffer.
module axi4_lite_reg_slice
  import axi4_lite_pkg::*;
#(
  parameter int A        = 32,
  parameter int N        = 4,
  parameter int USE_STRB = 1,
  parameter int AR_DEPTH = 2,
  parameter int AW_DEPTH = 2,
  parameter int W_DEPTH  = 2,
  parameter int B_DEPTH  = 2,
  parameter int R_DEPTH  = 2
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [A-1:0]                  s_araddr,
  input  logic                          s_arvalid,
  output logic                          s_arready,
  input  logic [A-1:0]                  s_awaddr,
  input  logic                          s_awvalid,
  output logic                          s_awready,
  input  logic [8*N-1:0]                s_wdata,
  input  logic [N-1:0]                  s_wstrb,
  input  logic                          s_wvalid,
  output logic                          s_wready,
  output logic [1:0]                    s_bresp,
  output logic                          s_bvalid,
  input  logic                          s_bready,
  output logic [8*N-1:0]                s_rdata,
  output logic [1:0]                    s_rresp,
  output logic                          s_rvalid,
  input  logic                          s_rready,
  output logic [A-1:0]                  m_araddr,
  output logic                          m_arvalid,
  input  logic                          m_arready,
  output logic [A-1:0]                  m_awaddr,
  output logic                          m_awvalid,
  input  logic                          m_awready,
  output logic [8*N-1:0]                m_wdata,
  output logic [N-1:0]                  m_wstrb,
  output logic                          m_wvalid,
  input  logic                          m_wready,
  input  logic [1:0]                    m_bresp,
  input  logic                          m_bvalid,
  output logic                          m_bready,
  input  logic [8*N-1:0]                m_rdata,
  input  logic [1:0]                    m_rresp,
  input  logic                          m_rvalid,
  output logic                          m_rready,
  output logic [cnt_w(AR_DEPTH)-1:0]    ar_count,
  output logic [cnt_w(AW_DEPTH)-1:0]    aw_count,
  output logic [cnt_w(W_DEPTH)-1:0]     w_count,
  output logic [cnt_w(B_DEPTH)-1:0]     b_count,
  output logic [cnt_w(R_DEPTH)-1:0]     r_count
);

  localparam int AR_PW = ar_w(A);
  localparam int AW_PW = aw_w(A);
  localparam int W_PW  = w_w(N, USE_STRB);
  localparam int B_PW  = b_w();
  localparam int R_PW  = r_w(N);

  logic [W_PW-1:0] w_in, w_out;
  logic [R_PW-1:0] r_in, r_out;

  if (USE_STRB != 0) begin : g_strb
    assign w_in    = {s_wdata, s_wstrb};
    assign m_wdata = w_out[W_PW-1 -: 8*N];
    assign m_wstrb = w_out[N-1:0];
  end else begin : g_nostrb
    logic unused_strb;
    assign unused_strb = ^s_wstrb;
    assign w_in        = s_wdata;
    assign m_wdata     = w_out;
    assign m_wstrb     = '1;
  end

  assign r_in    = {m_rdata, m_rresp};
  assign s_rdata = r_out[R_PW-1 -: 8*N];
  assign s_rresp = r_out[1:0];

  axi4_lite_chan_buf #(.W(AR_PW), .DEPTH(AR_DEPTH)) u_ar (
    .aclk(aclk), .areset(areset),
    .in_data(s_araddr), .in_valid(s_arvalid), .in_ready(s_arready),
    .out_data(m_araddr), .out_valid(m_arvalid), .out_ready(m_arready),
    .count(ar_count));

  axi4_lite_chan_buf #(.W(AW_PW), .DEPTH(AW_DEPTH)) u_aw (
    .aclk(aclk), .areset(areset),
    .in_data(s_awaddr), .in_valid(s_awvalid), .in_ready(s_awready),
    .out_data(m_awaddr), .out_valid(m_awvalid), .out_ready(m_awready),
    .count(aw_count));

  axi4_lite_chan_buf #(.W(W_PW), .DEPTH(W_DEPTH)) u_w (
    .aclk(aclk), .areset(areset),
    .in_data(w_in), .in_valid(s_wvalid), .in_ready(s_wready),
    .out_data(w_out), .out_valid(m_wvalid), .out_ready(m_wready),
    .count(w_count));

  axi4_lite_chan_buf #(.W(B_PW), .DEPTH(B_DEPTH)) u_b (
    .aclk(aclk), .areset(areset),
    .in_data(m_bresp), .in_valid(m_bvalid), .in_ready(m_bready),
    .out_data(s_bresp), .out_valid(s_bvalid), .out_ready(s_bready),
    .count(b_count));

  axi4_lite_chan_buf #(.W(R_PW), .DEPTH(R_DEPTH)) u_r (
    .aclk(aclk), .areset(areset),
    .in_data(r_in), .in_valid(m_rvalid), .in_ready(m_rready),
    .out_data(r_out), .out_valid(s_rvalid), .out_ready(s_rready),
    .count(r_count));

endmodule

// File: tb/tb_axi4_lite_reg_slice.sv
// Directed and randomized checks of the register slice against a queue-based channel model.
module tb_axi4_lite_reg_slice;

  logic        aclk, areset;
  logic [31:0] s_araddr, s_awaddr, s_wdata, s_rdata, m_araddr, m_awaddr, m_wdata, m_rdata;
  logic [3:0]  s_wstrb, m_wstrb;
  logic [1:0]  s_bresp, s_rresp, m_bresp, m_rresp;
  logic        s_arvalid, s_arready, s_awvalid, s_awready, s_wvalid, s_wready;
  logic        s_bvalid, s_bready, s_rvalid, s_rready;
  logic        m_arvalid, m_arready, m_awvalid, m_awready, m_wvalid, m_wready;
  logic        m_bvalid, m_bready, m_rvalid, m_rready;
  logic [1:0]  ar_count, aw_count;
  logic [2:0]  w_count, r_count;
  logic [0:0]  b_count;

  logic [31:0] n_wdata, n_m_wdata, n_s_rdata, n_m_araddr, n_m_awaddr;
  logic [3:0]  n_wstrb, n_m_wstrb;
  logic        n_wvalid, n_wready, n_m_wvalid, n_m_wready;
  logic [1:0]  n_s_bresp, n_s_rresp;
  logic        n_s_arready, n_s_awready, n_s_bvalid, n_s_rvalid;
  logic        n_m_arvalid, n_m_awvalid, n_m_bready, n_m_rready;
  logic [1:0]  n_ar_count, n_aw_count, n_w_count, n_b_count, n_r_count;

  int checks = 0;
  int failures = 0;

  axi4_lite_reg_slice #(.A(32), .N(4), .USE_STRB(1), .AR_DEPTH(2), .AW_DEPTH(2),
                        .W_DEPTH(4), .B_DEPTH(0), .R_DEPTH(4)) dut (
    .aclk(aclk), .areset(areset),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .ar_count(ar_count), .aw_count(aw_count), .w_count(w_count),
    .b_count(b_count), .r_count(r_count));

  axi4_lite_reg_slice #(.A(32), .N(4), .USE_STRB(0)) u_nostrb (
    .aclk(aclk), .areset(areset),
    .s_araddr(32'h0), .s_arvalid(1'b0), .s_arready(n_s_arready),
    .s_awaddr(32'h0), .s_awvalid(1'b0), .s_awready(n_s_awready),
    .s_wdata(n_wdata), .s_wstrb(n_wstrb), .s_wvalid(n_wvalid), .s_wready(n_wready),
    .s_bresp(n_s_bresp), .s_bvalid(n_s_bvalid), .s_bready(1'b1),
    .s_rdata(n_s_rdata), .s_rresp(n_s_rresp), .s_rvalid(n_s_rvalid), .s_rready(1'b1),
    .m_araddr(n_m_araddr), .m_arvalid(n_m_arvalid), .m_arready(1'b1),
    .m_awaddr(n_m_awaddr), .m_awvalid(n_m_awvalid), .m_awready(1'b1),
    .m_wdata(n_m_wdata), .m_wstrb(n_m_wstrb), .m_wvalid(n_m_wvalid), .m_wready(n_m_wready),
    .m_bresp(2'b00), .m_bvalid(1'b0), .m_bready(n_m_bready),
    .m_rdata(32'h0), .m_rresp(2'b00), .m_rvalid(1'b0), .m_rready(n_m_rready),
    .ar_count(n_ar_count), .aw_count(n_aw_count), .w_count(n_w_count),
    .b_count(n_b_count), .r_count(n_r_count));

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: each buffered channel is an ordered queue bounded by its depth.
  logic [31:0] qar[$];
  logic [35:0] qw[$];
  logic [33:0] qr[$];
  bit ar_in, ar_out, w_in, w_out, r_in, r_out;
  int exp_i, nxt_i;

  initial begin
    areset = 1'b1;
    s_araddr = 32'h10; s_arvalid = 1'b1; s_awaddr = '0; s_awvalid = 1'b0;
    s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0; s_bready = 1'b0; s_rready = 1'b0;
    m_arready = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
    m_bresp = '0; m_bvalid = 1'b0; m_rdata = '0; m_rresp = '0; m_rvalid = 1'b0;
    n_wdata = '0; n_wstrb = '0; n_wvalid = 1'b0; n_m_wready = 1'b0;

    // Reset held for three cycles with a pending AR request
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_arvalid", m_arvalid, 0);
      chk("rst_arready", s_arready, 0);
      chk("rst_ar_count", ar_count, 0);
      chk("rst_wvalid_count", {m_wvalid, w_count}, 0);
      chk("rst_rvalid_count", {s_rvalid, r_count}, 0);
      chk("rst_wready", s_wready, 0);
    end
    areset = 1'b0;
    s_arvalid = 1'b0;
    chk("post_rst_arready_cycle0", s_arready, 0);
    tick();
    chk("post_rst_arready_cycle1", s_arready, 1);
    chk("post_rst_awready", s_awready, 1);
    chk("post_rst_wready", s_wready, 1);
    chk("post_rst_rready", m_rready, 1);
    chk("post_rst_arvalid", m_arvalid, 0);

    // Skid buffer under back-pressure
    s_arvalid = 1'b1; s_araddr = 32'h10; tick();
    chk("skid_one_count", ar_count, 1);
    s_araddr = 32'h14; tick();
    chk("skid_full_ready", s_arready, 0);
    s_araddr = 32'h18; tick();
    chk("skid_full_count", ar_count, 2);
    chk("skid_full_head", m_araddr, 32'h10);
    m_arready = 1'b1; tick();
    chk("skid_drain_1", {m_arvalid, m_araddr}, {1'b1, 32'h14});
    tick();
    s_arvalid = 1'b0;
    chk("skid_drain_2", {m_arvalid, m_araddr}, {1'b1, 32'h18});
    chk("skid_drain_2_count", ar_count, 1);
    tick();
    chk("skid_empty", {m_arvalid, ar_count}, 0);
    m_arready = 1'b0;

    // FIFO fill, blocked push, then drain with wrap-around
    for (int i = 1; i <= 4; i++) begin
      s_wvalid = 1'b1; s_wdata = i; s_wstrb = 4'hF; tick();
    end
    s_wdata = 5; tick(); tick();
    chk("fifo_full_count", w_count, 4);
    chk("fifo_full_ready", s_wready, 0);
    chk("fifo_full_head", m_wdata, 1);
    m_wready = 1'b1; exp_i = 1; nxt_i = 5;
    for (int c = 0; c < 20 && exp_i <= 6; c++) begin
      s_wvalid = (nxt_i <= 6); s_wdata = nxt_i;
      if (m_wvalid) begin
        chk("fifo_order", {m_wdata, m_wstrb}, {exp_i[31:0], 4'hF});
        exp_i++;
      end
      chk("fifo_no_overflow", w_count <= 4, 1);
      if (s_wvalid && s_wready) nxt_i++;
      tick();
    end
    s_wvalid = 1'b0; m_wready = 1'b0;
    chk("fifo_drain_done", exp_i, 7);
    chk("fifo_empty", {m_wvalid, w_count}, 0);

    // R FIFO drained from full while the source keeps pushing
    for (int i = 0; i < 4; i++) begin
      m_rvalid = 1'b1; m_rdata = 32'hA0 + i; m_rresp = i[1:0]; tick();
    end
    chk("r_full_count", r_count, 4);
    chk("r_full_ready", m_rready, 0);
    s_rready = 1'b1; exp_i = 0; nxt_i = 4;
    for (int c = 0; c < 16 && exp_i < 10; c++) begin
      m_rvalid = (nxt_i < 10); m_rdata = 32'hA0 + nxt_i; m_rresp = nxt_i[1:0];
      if (c == 1) chk("r_full_pop_blocks_push", r_count, 3);
      if (s_rvalid) begin
        chk("r_order", {s_rdata, s_rresp}, {32'hA0 + exp_i[31:0], exp_i[1:0]});
        exp_i++;
      end
      chk("r_no_overflow", r_count <= 4, 1);
      if (m_rvalid && m_rready) nxt_i++;
      tick();
    end
    m_rvalid = 1'b0; s_rready = 1'b0;
    chk("r_drain_done", exp_i, 10);
    chk("r_empty", {s_rvalid, r_count}, 0);

    // B pass-through is combinational in both directions
    m_bvalid = 1'b1; m_bresp = 2'b10; s_bready = 1'b0; #1;
    chk("b_pass_fwd", {s_bvalid, s_bresp}, {1'b1, 2'b10});
    chk("b_pass_ready0", m_bready, 0);
    s_bready = 1'b1; #1;
    chk("b_pass_ready1", m_bready, 1);
    chk("b_pass_count", b_count, 0);
    m_bvalid = 1'b0; s_bready = 1'b0;
    tick();

    // Strobe dropped on the second slice
    n_wvalid = 1'b1; n_wdata = 32'hDEADBEEF; n_wstrb = 4'h3; n_m_wready = 1'b1; #1;
    chk("nostrb_strb", n_m_wstrb, 4'hF);
    chk("nostrb_not_yet", n_m_wvalid, 0);
    tick();
    n_wvalid = 1'b0;
    chk("nostrb_data", {n_m_wvalid, n_m_wdata, n_m_wstrb}, {1'b1, 32'hDEADBEEF, 4'hF});
    tick();
    chk("nostrb_empty", n_m_wvalid, 0);

    // Randomized traffic on AR (skid), W and R (FIFOs) against the queue model
    qar.delete(); qw.delete(); qr.delete();
    for (int c = 0; c < 400; c++) begin
      chk("rnd_ar_valid", m_arvalid, qar.size() != 0);
      if (qar.size() != 0) chk("rnd_ar_data", m_araddr, qar[0]);
      chk("rnd_ar_ready", s_arready, qar.size() < 2);
      chk("rnd_ar_count", ar_count, qar.size());
      chk("rnd_w_valid", m_wvalid, qw.size() != 0);
      if (qw.size() != 0) chk("rnd_w_data", {m_wdata, m_wstrb}, qw[0]);
      chk("rnd_w_ready", s_wready, qw.size() < 4);
      chk("rnd_w_count", w_count, qw.size());
      chk("rnd_r_valid", s_rvalid, qr.size() != 0);
      if (qr.size() != 0) chk("rnd_r_data", {s_rdata, s_rresp}, qr[0]);
      chk("rnd_r_ready", m_rready, qr.size() < 4);
      chk("rnd_r_count", r_count, qr.size());

      ar_in  = s_arvalid && (qar.size() < 2);
      ar_out = (qar.size() != 0) && m_arready;
      w_in   = s_wvalid && (qw.size() < 4);
      w_out  = (qw.size() != 0) && m_wready;
      r_in   = m_rvalid && (qr.size() < 4);
      r_out  = (qr.size() != 0) && s_rready;
      @(posedge aclk);
      if (ar_out) void'(qar.pop_front());
      if (ar_in) qar.push_back(s_araddr);
      if (w_out) void'(qw.pop_front());
      if (w_in) qw.push_back({s_wdata, s_wstrb});
      if (r_out) void'(qr.pop_front());
      if (r_in) qr.push_back({m_rdata, m_rresp});
      #1;
      if (!s_arvalid || ar_in) begin
        s_arvalid = 1'($urandom_range(0, 1)); s_araddr = $urandom;
      end
      if (!s_wvalid || w_in) begin
        s_wvalid = 1'($urandom_range(0, 1)); s_wdata = $urandom; s_wstrb = 4'($urandom);
      end
      if (!m_rvalid || r_in) begin
        m_rvalid = 1'($urandom_range(0, 1)); m_rdata = $urandom; m_rresp = 2'($urandom);
      end
      m_arready = 1'($urandom_range(0, 3) != 0 ? (c % 64 < 40) : 0);
      m_wready  = 1'($urandom_range(0, 1));
      s_rready  = 1'($urandom_range(0, 2) != 0 ? (c % 50 < 30) : 0);
    end

    // Fill some buffers, then reset mid-transfer: everything buffered is discarded
    m_arready = 1'b0; m_wready = 1'b0; s_rready = 1'b0;
    s_arvalid = 1'b1; s_wvalid = 1'b1; m_rvalid = 1'b1;
    tick(); tick();
    chk("pre_midrst_ar_busy", ar_count != 0, 1);
    areset = 1'b1;
    tick();
    chk("midrst_valids", {m_arvalid, m_wvalid, s_rvalid}, 0);
    chk("midrst_counts", {ar_count, w_count, r_count}, 0);
    chk("midrst_readys", {s_arready, s_wready, m_rready}, 0);
    areset = 1'b0;
    s_arvalid = 1'b0; s_wvalid = 1'b0; m_rvalid = 1'b0;
    tick(); tick();
    chk("after_midrst_ready", {s_arready, s_wready, m_rready}, 3'b111);
    chk("after_midrst_empty", {m_arvalid, m_wvalid, s_rvalid}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
